if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU. Holds the program counter, reads a word-addressed instruction ROM, and loads the IF/ID pipeline register that feeds the decode stage. Accepts a stall from the hazard unit and a PC redirect with flush from branch/jump resolution in EXE. Also keeps a fetched-instruction counter for debug and bench checks.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/if_stage_if.sv | 20 ++
 rtl/instr_rom.sv | 19 +
 rtl/if_stage.sv | 46 ++++
 tb/tb_if_stage.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, NOP encoding and PC constants for the pipeline stages
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: control inputs and IF/ID outputs of the fetch stage
interface if_stage_if;
  import cpu_pkg::*;
  logic stall;
  logic redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] if_id_instr;
  logic [WORD_W-1:0] if_id_pc4;
  logic if_id_valid;
  logic [WORD_W-1:0] fetch_cnt;
  modport master (
    output stall, redirect, redirect_pc,
    input pc, if_id_instr, if_id_pc4, if_id_valid, fetch_cnt
  );
  modport slave (
    input stall, redirect, redirect_pc,
    output pc, if_id_instr, if_id_pc4, if_id_valid, fetch_cnt
  );
endinterface

// File: rtl/instr_rom.sv
// instr_rom: combinational word-addressed instruction ROM, NOP beyond the image
module instr_rom
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter string IMEM_FILE = "imem.hex",
  parameter logic [IMEM_DEPTH*WORD_W-1:0] IMEM_INIT = '0
) (
  input  logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] data
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [IMEM_DEPTH-1:0][WORD_W-1:0] rom;
  logic [WORD_W-1:0] word;
  assign rom = IMEM_INIT;
  assign word = addr >> 2;
  // any address past the image reads as NOP rather than aliasing back into it
  assign data = word < WORD_W'(IMEM_DEPTH) ? rom[word[AW-1:0]] : NOP_INSTR;
endmodule

// File: rtl/if_stage.sv
// if_stage: program counter, ROM fetch and IF/ID register with stall and redirect-flush
module if_stage
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter string IMEM_FILE = "imem.hex",
  parameter logic [IMEM_DEPTH*WORD_W-1:0] IMEM_INIT = '0
) (
  input logic clk,
  input logic reset_pc,
  if_stage_if.slave bus
);
  logic [WORD_W-1:0] rom_data;
  logic [WORD_W-1:0] pc_seq;
  instr_rom #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .IMEM_FILE(IMEM_FILE),
    .IMEM_INIT(IMEM_INIT)
  ) u_rom (
    .addr(bus.pc),
    .data(rom_data)
  );
  assign pc_seq = bus.pc + PC_STEP;
  // redirect beats stall so a flushed slot never waits behind a hazard
  always_ff @(posedge clk) begin
    if (!reset_pc) begin
      bus.pc <= RESET_PC;
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_pc4 <= '0;
      bus.if_id_valid <= 1'b0;
      bus.fetch_cnt <= '0;
    end else if (bus.redirect) begin
      bus.pc <= word_align(bus.redirect_pc);
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_pc4 <= '0;
      bus.if_id_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.pc <= pc_seq;
      bus.if_id_instr <= rom_data;
      bus.if_id_pc4 <= pc_seq;
      bus.if_id_valid <= 1'b1;
      bus.fetch_cnt <= bus.fetch_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan checks plus randomized run against a behavioural fetch model
module tb_if_stage;
  localparam int DEPTH = 64;

  function automatic logic [31:0] rom_val(input int i);
    case (i)
      0: return 32'h2001_0005;
      1: return 32'h2002_0003;
      2: return 32'h0022_1820;
      3: return 32'h0000_0000;
      default: return 32'hA000_0000 | (32'(i) << 16) | 32'(i);
    endcase
  endfunction

  function automatic logic [DEPTH*32-1:0] build_img();
    logic [DEPTH*32-1:0] img;
    for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = rom_val(i);
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] IMG = build_img();

  logic clk = 0;
  logic reset_pc;
  if_stage_if bus();

  if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .IMEM_INIT(IMG)) dut (
    .clk(clk),
    .reset_pc(reset_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return (a < 32'(4 * DEPTH)) ? rom_val(int'(a / 4)) : 32'h0;
  endfunction

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic m_valid;
  bit started = 0;

  initial forever begin
    @(posedge clk);
    if (!reset_pc) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_cnt = 0;
    end else if (bus.redirect) begin
      m_pc = bus.redirect_pc - (bus.redirect_pc % 4);
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
    end else if (!bus.stall) begin
      m_instr = fetch_word(m_pc);
      m_pc = m_pc + 4;
      m_pc4 = m_pc;
      m_valid = 1;
      m_cnt = m_cnt + 1;
    end
    started = 1;
    #1;
    chk("pc", bus.pc, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_pc4", bus.if_id_pc4, m_pc4);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
  end

  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    reset_pc = r; bus.stall = s; bus.redirect = rd; bus.redirect_pc = rpc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_pc = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    cyc(0, 0, 0, 0);
    chk("rst pc", bus.pc, 32'h0);
    chk("rst valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst cnt", bus.fetch_cnt, 32'h0);
    chk("rst instr", bus.if_id_instr, 32'h0);
    cyc(1, 0, 0, 0);
    chk("e1 instr", bus.if_id_instr, 32'h2001_0005);
    chk("e1 pc4", bus.if_id_pc4, 32'h4);
    chk("e1 cnt", bus.fetch_cnt, 32'd1);
    cyc(1, 0, 0, 0);
    chk("e2 instr", bus.if_id_instr, 32'h2002_0003);
    chk("e2 pc", bus.pc, 32'h8);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("stall pc", bus.pc, 32'h8);
    chk("stall instr", bus.if_id_instr, 32'h2002_0003);
    chk("stall cnt", bus.fetch_cnt, 32'd2);
    cyc(1, 0, 0, 0);
    chk("resume instr", bus.if_id_instr, 32'h0022_1820);
    chk("resume pc", bus.pc, 32'd12);
    chk("resume cnt", bus.fetch_cnt, 32'd3);
    cyc(0, 0, 0, 0);
    chk("midrst pc", bus.pc, 32'h0);
    chk("midrst valid", 32'(bus.if_id_valid), 32'h0);
    chk("midrst cnt", bus.fetch_cnt, 32'h0);
    cyc(1, 0, 0, 0);
    chk("refetch instr", bus.if_id_instr, 32'h2001_0005);
    cyc(1, 1, 1, 32'h0000_0013);
    chk("redir pc", bus.pc, 32'h10);
    chk("redir valid", 32'(bus.if_id_valid), 32'h0);
    chk("redir instr", bus.if_id_instr, 32'h0);
    cyc(1, 0, 0, 0);
    chk("tgt instr", bus.if_id_instr, 32'hA004_0004);
    chk("tgt pc4", bus.if_id_pc4, 32'h14);
    cyc(1, 0, 1, 32'hFFFF_FFFC);
    chk("far pc", bus.pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("oor instr", bus.if_id_instr, 32'h0);
    chk("oor valid", 32'(bus.if_id_valid), 32'h1);
    chk("oor pc4", bus.if_id_pc4, 32'h0);
    chk("wrap pc", bus.pc, 32'h0);
    cyc(1, 0, 0, 0);
    chk("wrap fetch", bus.if_id_instr, 32'h2001_0005);
    for (int n = 0; n < 400; n++) begin
      logic r, s, rd;
      logic [31:0] t;
      r = $urandom_range(0, 49) != 0;
      s = $urandom_range(0, 3) == 0;
      rd = $urandom_range(0, 9) == 0;
      t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      cyc(r, s, rd, t);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
